// File: rtl/jtag_drv_pkg.sv
// rtl/jtag_drv_pkg.sv - op codes, header TMS patterns and TAP instruction codes for the JTAG driver
package jtag_drv_pkg;

    typedef enum logic [1:0] {
        OP_RESET   = 2'b00,
        OP_IDLE    = 2'b01,
        OP_IR_SCAN = 2'b10,
        OP_DR_SCAN = 2'b11
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_SHIFT,
        ST_TRL,
        ST_DONE
    } drv_state_e;

    // Header TMS patterns, bit 0 emitted first.
    localparam int HDR_W = 5;
    localparam logic [HDR_W-1:0] HDR_TMS_IR    = 5'b00011;
    localparam logic [HDR_W-1:0] HDR_TMS_DR    = 5'b00001;
    localparam logic [HDR_W-1:0] HDR_TMS_RESET = 5'b11111;
    localparam int HDR_LEN_IR    = 4;
    localparam int HDR_LEN_DR    = 3;
    localparam int HDR_LEN_RESET = 5;

    localparam logic [3:0] INSTR_BYPASS         = 4'hF;
    localparam logic [3:0] INSTR_SAMPLE_PRELOAD = 4'h1;
    localparam logic [3:0] INSTR_IDCODE         = 4'h2;
    localparam logic [3:0] INSTR_BIST           = 4'h3;
    localparam logic [3:0] INSTR_EXTEST         = 4'h4;
    localparam logic [3:0] INSTR_BIST_CONF      = 4'h5;
    localparam logic [3:0] INSTR_BIST_STATUS    = 4'h7;
    localparam logic [3:0] INSTR_INTEST         = 4'h8;
    localparam logic [3:0] INSTR_BIST_USER_TEST = 4'h9;

    function automatic logic hdr_tms(input jtag_op_e op, input int idx);
        logic [HDR_W-1:0] pat;
        logic [HDR_W-1:0] sel;
        case (op)
            OP_IR_SCAN: pat = HDR_TMS_IR;
            OP_DR_SCAN: pat = HDR_TMS_DR;
            OP_RESET:   pat = HDR_TMS_RESET;
            default:    pat = '0;
        endcase
        sel = pat >> idx;
        return sel[0];
    endfunction

    function automatic int hdr_len_of(input jtag_op_e op);
        case (op)
            OP_IR_SCAN: return HDR_LEN_IR;
            OP_DR_SCAN: return HDR_LEN_DR;
            OP_RESET:   return HDR_LEN_RESET;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider with registered TCK and same-cycle rise/fall strobes
module jtag_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic park,
    output logic tck,
    output logic rise,
    output logic fall,
    output logic low_end
);

    localparam int CNT_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

    logic [CNT_W-1:0] cnt;
    logic             term;

    // Strobes flag the CLK edge on which TCK toggles; park holds TCK low at the end of a low phase.
    assign term    = en && (cnt == CNT_W'(TCK_HALF - 1));
    assign fall    = term && tck;
    assign low_end = term && !tck;
    assign rise    = low_end && !park;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (term) begin
            cnt <= '0;
            if (fall) begin
                tck <= 1'b0;
            end else if (rise) begin
                tck <= 1'b1;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_tap_driver.sv
// rtl/jtag_tap_driver.sv - JTAG master turning host scan commands into TCK/TMS/TDI and capturing TDO
module jtag_tap_driver
    import jtag_drv_pkg::*;
#(
    parameter int TCK_HALF = 2,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [LEN_W-1:0]   CMD_LEN,
    input  logic [MAX_LEN-1:0] CMD_DATA,
    output logic               RSP_VALID,
    output logic [MAX_LEN-1:0] RSP_DATA,
    output logic               BUSY,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    localparam int NW = $clog2(MAX_LEN + 1);
    localparam int IW = (LEN_W > NW) ? LEN_W : NW;

    drv_state_e         state;
    jtag_op_e           op;
    jtag_op_e           op_in;
    logic [IW-1:0]      n;
    logic [IW-1:0]      hdr_bits;
    logic [IW-1:0]      idx;
    logic [MAX_LEN-1:0] data;
    logic [MAX_LEN-1:0] cap;
    logic               in_tlr;
    logic               run;
    logic [IW-1:0]      len_ext;
    logic [IW-1:0]      n_clamped;
    logic [IW-1:0]      shamt;
    logic               tck_rise;
    logic               tck_fall;
    logic               tck_low_end;

    assign op_in   = jtag_op_e'(CMD_OP);
    assign len_ext = IW'(CMD_LEN);
    // Captured bits enter at the MSB, so the response is right-aligned by MAX_LEN-N.
    assign shamt   = IW'(MAX_LEN) - n;

    always_comb begin
        n_clamped = len_ext;
        if (len_ext == '0) begin
            n_clamped = IW'(1);
        end else if (len_ext > IW'(MAX_LEN)) begin
            n_clamped = IW'(MAX_LEN);
        end
    end

    jtag_tck_gen #(
        .TCK_HALF(TCK_HALF)
    ) u_tck_gen (
        .clk    (CLK),
        .rst    (RST),
        .en     (run),
        .park   (state == ST_DONE),
        .tck    (TCK),
        .rise   (tck_rise),
        .fall   (tck_fall),
        .low_end(tck_low_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            op        <= OP_RESET;
            n         <= '0;
            hdr_bits  <= '0;
            idx       <= '0;
            data      <= '0;
            cap       <= '0;
            in_tlr    <= 1'b1;
            run       <= 1'b0;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        op        <= op_in;
                        n         <= n_clamped;
                        hdr_bits  <= (op_in == OP_IDLE) ? len_ext : IW'(hdr_len_of(op_in));
                        idx       <= '0;
                        data      <= CMD_DATA;
                        cap       <= '0;
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        TDI       <= 1'b0;
                        if (op_in == OP_IDLE && CMD_LEN == '0) begin
                            state <= ST_DONE;
                            run   <= 1'b0;
                        end else begin
                            run <= 1'b1;
                            if (in_tlr && (op_in == OP_IR_SCAN || op_in == OP_DR_SCAN)) begin
                                state <= ST_PRE;
                                TMS   <= 1'b0;
                            end else begin
                                state <= ST_HDR;
                                TMS   <= hdr_tms(op_in, 0);
                            end
                        end
                    end
                end
                ST_PRE: begin
                    if (tck_fall) begin
                        state <= ST_HDR;
                        idx   <= '0;
                        TMS   <= hdr_tms(op, 0);
                    end
                end
                ST_HDR: begin
                    if (tck_fall) begin
                        if (idx != hdr_bits - IW'(1)) begin
                            idx <= idx + IW'(1);
                            TMS <= hdr_tms(op, int'(idx) + 1);
                        end else if (op == OP_RESET) begin
                            state  <= ST_DONE;
                            in_tlr <= 1'b1;
                        end else if (op == OP_IDLE) begin
                            state  <= ST_DONE;
                            in_tlr <= 1'b0;
                        end else begin
                            state <= ST_SHIFT;
                            idx   <= '0;
                            TMS   <= (n == IW'(1));
                            TDI   <= data[0];
                            data  <= data >> 1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tck_rise) begin
                        cap <= {TDO, cap[MAX_LEN-1:1]};
                    end
                    if (tck_fall) begin
                        if (idx != n - IW'(1)) begin
                            idx  <= idx + IW'(1);
                            TMS  <= ((idx + IW'(2)) == n);
                            TDI  <= data[0];
                            data <= data >> 1;
                        end else begin
                            state <= ST_TRL;
                            idx   <= '0;
                            TMS   <= 1'b1;
                            TDI   <= 1'b0;
                        end
                    end
                end
                ST_TRL: begin
                    if (tck_fall) begin
                        if (idx == '0) begin
                            idx <= IW'(1);
                            TMS <= 1'b0;
                        end else begin
                            state  <= ST_DONE;
                            in_tlr <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (!run || tck_low_end) begin
                        state     <= ST_IDLE;
                        run       <= 1'b0;
                        BUSY      <= 1'b0;
                        CMD_READY <= 1'b1;
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= cap >> shamt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
Hardware JTAG master that sits directly upstream of main_module. It converts host scan commands into TCK/TMS/TDI waveforms and captures TDO, replacing the bench-level command/data tasks with synthesizable logic. Each command starts and ends in Run-Test/Idle (RTI), except RESET, which ends in Test-Logic-Reset (TLR).

Parameters:
TCK_HALF, 2, CLK cycles per TCK half-period (>=1); TCK period = 2*TCK_HALF CLK cycles
MAX_LEN, 16, maximum scan length in bits; also width of CMD_DATA and RSP_DATA
LEN_W, 5, width of CMD_LEN

Ports:
CLK  in  1  system clock; sole clock of the block
RST  in  1  synchronous reset, active-high
CMD_VALID  in  1  command request
CMD_READY  out  1  driver idle and able to accept a command
CMD_OP  in  2  00 RESET, 01 IDLE, 10 IR_SCAN, 11 DR_SCAN
CMD_LEN  in  LEN_W  scan bit count, or RTI cycle count for IDLE
CMD_DATA  in  MAX_LEN  TDI bits, LSB shifted first
RSP_VALID  out  1  one-cycle pulse: command complete
RSP_DATA  out  MAX_LEN  captured TDO bits, LSB = first shifted out
BUSY  out  1  command in progress
TCK  out  1  JTAG clock to the TAP
TMS  out  1  JTAG mode select
TDI  out  1  JTAG data to the TAP
TDO  in  1  JTAG data from the TAP

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, RSP_VALID=0, RSP_DATA=0, BUSY=0, CMD_READY=0 during RST, then 1. Internal in_tlr flag = 1.
- Handshake:
  - Command accepted on the CLK edge where CMD_VALID & CMD_READY; CMD_* are latched at that edge.
  - CMD_READY drops the next cycle and BUSY rises.
  - CMD_VALID is ignored while BUSY.
- Bit period timing:
  - One bit = one TCK period.
  - TMS/TDI update together with TCK falling (or, for the first bit, the cycle after accept, with TCK low).
  - TCK rises TCK_HALF cycles later. TDO is sampled on the CLK edge that drives TCK high.
  - Between commands TCK is held low. TMS holds 0 after scan/IDLE and 1 after RESET.
- FSM states: IDLE, PRE, HDR, SHIFT, TRL, DONE.
  - PRE: one TMS=0 bit (TLR->RTI), emitted only if in_tlr and op is IR_SCAN/DR_SCAN.
  - HDR, IR_SCAN: TMS 1,1,0,0.
  - HDR, DR_SCAN: TMS 1,0,0.
  - HDR, RESET: TMS 1,1,1,1,1, then go to DONE and set in_tlr.
  - SHIFT: N=max(CMD_LEN,1) bits, clamped to MAX_LEN.
    - TDI = CMD_DATA[i].
    - TMS=0 except the last bit, which has TMS=1 (Shift->Exit1).
    - TDO sampled at bit i's rising edge goes to RSP_DATA[i]; bits >= N are 0.
  - TRL: TMS 1 (Update), then 0 (RTI). Clears in_tlr.
  - IDLE op: CMD_LEN bits of TMS=0, TDI=0. CMD_LEN=0 emits no TCK edges. Clears in_tlr if CMD_LEN>0.
  - DONE: after the last bit's low phase, TCK stays low. RSP_VALID pulses 1 cycle, BUSY drops, CMD_READY=1 the same cycle.
- TCK period counts:
  - IR_SCAN = N+6 (+1 if PRE).
  - DR_SCAN = N+5 (+1 if PRE).
  - RESET = 5.
  - IDLE = CMD_LEN.
- RSP_DATA is 0 for RESET/IDLE and is held until the next RSP_VALID.
- RST mid-command:
  - Next edge forces TCK=0, TMS=1; the command is dropped with no RSP_VALID.
  - in_tlr=1, but TAP state is undefined; the host must issue RESET first.
- Back-to-back commands: a new command may be accepted in the cycle after RSP_VALID. No TCK glitch is allowed; the minimum low time is TCK_HALF.

Decomposition:
- jtag_drv_pkg holds:
  - op codes
  - HDR TMS patterns and lengths for each op
  - TAP instruction constants: BYPASS 4'hF, SAMPLE_PRELOAD 4'h1, IDCODE 4'h2, BIST 4'h3, EXTEST 4'h4, BIST_CONF 4'h5, BIST_STATUS 4'h7, INTEST 4'h8, BIST_USER_TEST 4'h9
- Sub-module jtag_tck_gen: TCK_HALF divider producing the registered TCK and one-cycle rise/fall strobes, enabled by BUSY.

Test Plan:
1. Post-reset RESET op, TCK_HALF=2 -> 5 TCK periods (20 CLK), TMS=1 all bits; RSP_VALID=1 with RSP_DATA=0; TMS stays 1.
2. After RESET, IR_SCAN LEN=4 DATA=4'h4 (EXTEST) -> TMS sequence 0,1,1,0,0,0,0,0,1,1,0 (11 periods); TDI bits 0,0,1,0 on shift periods; main_module IR=4'h4 after Update.
3. Then DR_SCAN LEN=4 DATA=4'b1111 -> 9 periods, no PRE; TMS 1,0,0,0,0,0,1,1,0; RSP_DATA[3:0] = prior boundary-register contents from the TAP model; PIN_OUT_1/2 updated.
4. DR_SCAN LEN=0 and LEN=20 -> both clamp: 6 and 21 periods respectively; RSP_DATA bits above N are 0.
5. IDLE LEN=0 -> RSP_VALID one cycle after accept with zero TCK edges; IDLE LEN=3 -> 3 periods with TMS=0.
6. RST asserted mid-SHIFT of DR_SCAN LEN=16 -> TCK=0, TMS=1 the next cycle; no RSP_VALID; CMD_READY=1 one cycle after RST deasserts; the next IR_SCAN includes PRE.
